// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered front-end for a combinational ALU.
// Takes operand/op commands over valid/ready and drives the ALU from
// registers. One cycle later it captures the ALU result and flags and
// offers them downstream over a second valid/ready handshake.
// An accumulator mode and a saturating overflow counter are included.
module alu_op_sequencer #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_acc,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_op,
    input  logic [W-1:0]     alu_f,
    input  logic             alu_zero,
    input  logic             alu_over,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_f,
    output logic [2:0]       res_flags,
    output logic [W-1:0]     acc,
    output logic [CNT_W-1:0] ovf_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_cmd_ready;
    logic             w_accept;

    logic [W-1:0]     r_alu_a;
    logic [W-1:0]     r_alu_b;
    logic [2:0]       r_alu_op;
    logic [W-1:0]     r_res_f;
    logic [2:0]       r_res_flags;
    logic [W-1:0]     r_acc;
    logic [CNT_W-1:0] r_ovf_cnt;

    // Next-state and command-ready decode; ready is forced low while in reset.
    always_comb begin
        w_cmd_ready  = 1'b0;
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                // A new command can only enter as the held result leaves.
                w_cmd_ready = res_ready;
                if (res_ready) begin
                    w_state_next = cmd_valid ? S_EXEC : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (!rst_n) begin
            w_cmd_ready = 1'b0;
        end
    end

    assign w_accept = cmd_valid & w_cmd_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch ALU operands on command acceptance; they hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else if (w_accept) begin
            // In HOLD the accumulator already carries the previous result.
            r_alu_a  <= cmd_acc ? r_acc : cmd_a;
            r_alu_b  <= cmd_b;
            r_alu_op <= cmd_op;
        end
    end

    // Capture the settled ALU outputs at the end of EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_f     <= '0;
            r_res_flags <= '0;
            r_acc       <= '0;
        end else if (r_state == S_EXEC) begin
            r_res_f     <= alu_f;
            r_res_flags <= {alu_over, alu_cout, alu_zero};
            r_acc       <= alu_f;
        end
    end

    // Count captured overflow results, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if ((r_state == S_EXEC) && alu_over &&
                     (r_ovf_cnt != {CNT_W{1'b1}})) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign res_valid = (r_state == S_HOLD);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign res_f     = r_res_f;
    assign res_flags = r_res_flags;
    assign acc       = r_acc;
    assign ovf_cnt   = r_ovf_cnt;

endmodule
